// File: rtl/feedback_mux_tree.sv
// Pipelined binary feedback mux tree: 2^LEVELS lanes of W bits reduce to one W-bit result.
// Optional select debug port enabled by defining FMT_SEL_DBG_EN.
module feedback_mux_tree #(
  parameter int LEVELS = 3,
  parameter int W      = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [(1 << LEVELS)*W-1:0] in_data,
  output logic                       out_valid,
  output logic [W-1:0]               out_data
`ifdef FMT_SEL_DBG_EN
  ,
  output logic [LEVELS-1:0]          sel_dbg
`endif
);

  localparam int N     = 1 << LEVELS;
  localparam int NODES = N - 1;

  logic [W-1:0]    prev_q [N];
  logic [W-1:0]    prev_d [N];
  logic [W-1:0]    node_q [NODES];
  logic [W-1:0]    node_d [NODES];
  logic [W-1:0]    tree   [2*N-1];
  logic [LEVELS:1] v_q;
  logic [LEVELS:1] ld;
  logic [LEVELS:1] sel;
  logic [LEVELS:0] hist_q;
  logic [LEVELS:0] hist_d;

  // tree[0..N-1] is the combinational layer 0; level k registers follow in order.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      prev_d[i] = in_valid ? in_data[i*W +: W] : prev_q[i];
      tree[i]   = prev_q[(i+1) % N][0] ? prev_q[i] : in_data[i*W +: W];
    end
    for (int n = 0; n < NODES; n++) begin
      tree[N+n] = node_q[n];
    end
  end

  always_comb begin
    ld    = '0;
    ld[1] = in_valid;
    for (int k = 2; k <= LEVELS; k++) begin
      ld[k] = v_q[k-1];
    end
    for (int k = 1; k <= LEVELS; k++) begin
      sel[k] = hist_q[LEVELS+1-k];
    end
  end

  // Level k entries sit at tree offset 2N - (2N >> k); its inputs at 2N - (4N >> k).
  always_comb begin
    node_d = node_q;
    for (int k = 1; k <= LEVELS; k++) begin
      for (int j = 0; j < (N >> k); j++) begin
        if (ld[k]) begin
          node_d[N - ((2*N) >> k) + j] = sel[k] ? tree[2*N - ((4*N) >> k) + 2*j + 1]
                                                : tree[2*N - ((4*N) >> k) + 2*j];
        end
      end
    end
  end

  assign out_valid = v_q[LEVELS];
  assign out_data  = node_q[NODES-1];
  assign hist_d    = out_valid ? {hist_q[LEVELS-1:0], out_data[0]} : hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) prev_q[i] <= '0;
      for (int n = 0; n < NODES; n++) node_q[n] <= '0;
      v_q    <= '0;
      hist_q <= '0;
    end else begin
      prev_q <= prev_d;
      node_q <= node_d;
      v_q    <= ld;
      hist_q <= hist_d;
    end
  end

`ifdef FMT_SEL_DBG_EN
  // Each level's entry carries the selects applied so far, bit k-1 = sel_k.
  logic [LEVELS-1:0] dbg_q [LEVELS];
  logic [LEVELS-1:0] dbg_d [LEVELS];

  always_comb begin
    dbg_d = dbg_q;
    if (ld[1]) dbg_d[0] = LEVELS'(sel[1]);
    for (int k = 2; k <= LEVELS; k++) begin
      if (ld[k]) dbg_d[k-1] = dbg_q[k-2] | (LEVELS'(sel[k]) << (k-1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LEVELS; k++) dbg_q[k] <= '0;
    end else begin
      dbg_q <= dbg_d;
    end
  end

  assign sel_dbg = dbg_q[LEVELS-1];
`endif

endmodule

// File: doc/feedback_mux_tree.md
Name: feedback_mux_tree

Overview:
- Parametrised, pipelined successor to the 8-input, 4-layer feedback mux network: 2^LEVELS lanes of W-bit data reduce through a binary tree of 2:1 muxes to one W-bit output.
- Layer-0 selects come from each lane's previous sample. Tree-level selects come from a delayed history of the output LSB.
- Adds parametrised width and depth, valid qualification, per-level pipeline registers and reset, none of which the first-generation network has.

Parameters:
- LEVELS, 3, tree depth; lane count N = 2^LEVELS (LEVELS 1..6).
- W, 1, data width per lane (1..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data holds a sample this cycle
- in_data  input  N*W  lane i at bits [i*W +: W]
- out_valid  output  1  out_data holds a result
- out_data  output  W  tree result

Behaviour:
- Reset (rst_n low, asynchronous):
  - Clears prev registers, all stage registers, stage valids, hist, out_valid and out_data to 0.
  - Outputs stay 0 until the first result emerges.
- prev: per-lane W-bit register, loaded with in_data only when in_valid=1.
- Layer 0 (combinational):
  - Lane i select s0[i] = prev[(i+1) mod N][0].
  - m0[i] = s0[i] ? prev[i] : in_data[i].
- Tree level k (k=1..LEVELS) is registered:
  - Entry j of level k = sel_k ? in[2j+1] : in[2j], j in 0..N/2^k-1.
  - The input is m0 for k=1, otherwise the level k-1 registers.
  - The level-k register and stage valid v_k load when v_(k-1)=1, with v_0=in_valid.
  - When v_(k-1)=0, v_k clears and the data register holds its value.
- out_data/out_valid are the level-LEVELS register and v_LEVELS.
  - Latency is LEVELS cycles from an accepted in_valid to out_valid.
  - Throughput is one result per cycle.
  - Bubbles propagate unchanged.
- Output history:
  - hist is a LEVELS+1 bit shift register.
  - On any cycle with out_valid=1: hist[0] <= out_data[0] and hist[j] <= hist[j-1].
  - hist holds its value when out_valid=0.
- Select timing: sel_k = hist[LEVELS+1-k], sampled in the cycle level k loads.
  - Widest level uses the oldest tap; the final level uses hist[1].
  - hist[0] is never used as a select.
- Simultaneous events: a stage load and a hist shift in the same cycle use the pre-shift hist value (ordinary register semantics).
- After reset all selects are 0:
  - First result equals lane 0 of the first accepted sample.
  - prev=0, so layer 0 passes current data.
- Reset mid-stream: in-flight samples are discarded and no out_valid is asserted for them; the first post-reset input behaves as after power-up.
- N=2 (LEVELS=1): one registered level using hist[1].

Optional Feature:
- Macro FMT_SEL_DBG_EN.
- When defined:
  - Adds output port sel_dbg, width LEVELS.
  - Bit k-1 is the sel_k value used to produce the current out_data, pipelined alongside the data.
  - Reset value is 0.
- When undefined: the port and its registers are absent. Data behaviour is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with random in_data and in_valid=1 -> out_valid=0 and out_data=0; deassert -> first out_valid exactly LEVELS cycles after the first accepted beat.
- LEVELS=3, W=4, lanes i=i+1 constant, single first beat -> first out_data=4'h1 (all selects 0).
- Same constant lanes, streaming -> hist picks up out LSBs; check every out_data against a bit-accurate model over 200 cycles, including the swing to lane 7 (4'h8) once hist taps are 1.
- Layer-0 select: prev lane1 LSB=1, lane0 prev=4'h3, current=4'hC, hist=0 -> out_data=4'h3 after 3 cycles.
- Bubbles: in_valid pattern 1,0,1,1,0 -> out_valid pattern identical, delayed 3 cycles; hist and prev frozen on the 0 cycles.
- Mid-stream reset: pulse rst_n low for 2 cycles during streaming -> no stale out_valid, and the post-reset sequence matches the post-power-up sequence.
- With FMT_SEL_DBG_EN: sel_dbg matches the model's {sel_3,sel_2,sel_1} for each result.
